// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states,
// and the request legality check.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} lsu_state_t;

   // funct3[1:0] is the access size for every legal load and store encoding.
   function automatic logic is_legal(input logic re, input logic we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
      logic f3_ok;
      logic align_ok;
      if (we)
         f3_ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
      else
         f3_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      case (funct3[1:0])
         2'b00:   align_ok = 1'b1;
         2'b01:   align_ok = ~addr_lo[0];
         2'b10:   align_ok = (addr_lo == 2'b00);
         default: align_ok = 1'b0;
      endcase
      return (re ^ we) && f3_ok && align_ok;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus: valid/ready request handshake plus a separate rvalid
// read response channel.
interface lsu_bus_if #(parameter int unsigned ADDR_W = 32);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [3:0]        wstrb;
   logic [31:0]       wdata;
   logic              rvalid;
   logic [31:0]       rdata;

   modport master (output valid, addr, we, wstrb, wdata,
                   input  ready, rvalid, rdata);
   modport slave  (input  valid, addr, we, wstrb, wdata,
                   output ready, rvalid, rdata);
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering: store strobes/replicated data and load
// shift plus sign/zero extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_data,
   output logic [3:0]  st_wstrb,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      st_wstrb = '0;
      st_wdata = '0;
      case (st_funct3)
         F3_SB: begin
            st_wstrb = 4'b0001 << st_addr_lo;
            st_wdata = {4{st_data[7:0]}};
         end
         F3_SH: begin
            st_wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         F3_SW: begin
            st_wstrb = '1;
            st_wdata = st_data;
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = ld_word >> {ld_addr_lo, 3'b000};
      ld_data = shifted;
      case (ld_funct3)
         F3_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  ld_data = {24'h000000, shifted[7:0]};
         F3_LHU:  ld_data = {16'h0000, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-side bridge between the single-cycle CPU and the word-wide memory bus;
// stalls the CPU for the duration of each load/store.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned BYTE_LANES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_re,
   input  logic              cpu_we,
   input  logic [2:0]        cpu_funct3,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              cpu_fault,
   lsu_bus_if.master         bus
);

   if (BYTE_LANES != 4) begin : g_lanes_check
      $error("load_store_unit: BYTE_LANES must be 4");
   end

   lsu_state_t        state_q;
   logic [2:0]        funct3_q;
   logic [1:0]        addr_lo_q;
   logic              valid_q;
   logic              we_q;
   logic [3:0]        wstrb_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic [ADDR_W-1:0] baddr_q;

   logic        req;
   logic        legal;
   logic        start;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

   assign req       = cpu_re | cpu_we;
   assign legal     = is_legal(cpu_re, cpu_we, cpu_funct3, cpu_addr[1:0]);
   assign start     = (state_q == IDLE) && legal;
   assign cpu_fault = !reset && (state_q == IDLE) && req && !legal;
   assign cpu_stall = start || (state_q == ADDR) || (state_q == RESP);
   assign cpu_rdata = rdata_q;

   assign bus.valid = valid_q;
   assign bus.addr  = baddr_q;
   assign bus.we    = we_q;
   assign bus.wstrb = wstrb_q;
   assign bus.wdata = wdata_q;

   // Store steering uses the live CPU request; load extraction uses the
   // latched access so the captured word is aligned after the bus returns it.
   lsu_lane_align u_align (
      .st_funct3  (cpu_funct3),
      .st_addr_lo (cpu_addr[1:0]),
      .st_data    (cpu_wdata),
      .st_wstrb   (st_wstrb),
      .st_wdata   (st_wdata),
      .ld_funct3  (funct3_q),
      .ld_addr_lo (addr_lo_q),
      .ld_word    (bus.rdata),
      .ld_data    (ld_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         funct3_q  <= '0;
         addr_lo_q <= '0;
         valid_q   <= 1'b0;
         we_q      <= 1'b0;
         wstrb_q   <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         baddr_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= ADDR;
                  valid_q   <= 1'b1;
                  baddr_q   <= {cpu_addr[ADDR_W-1:2], 2'b00};
                  we_q      <= cpu_we;
                  funct3_q  <= cpu_funct3;
                  addr_lo_q <= cpu_addr[1:0];
                  wstrb_q   <= cpu_we ? st_wstrb : '0;
                  wdata_q   <= cpu_we ? st_wdata : '0;
               end
            end
            ADDR: begin
               if (bus.ready) begin
                  valid_q <= 1'b0;
                  if (we_q) begin
                     state_q <= DONE;
                  end else if (bus.rvalid) begin
                     rdata_q <= ld_data;
                     state_q <= DONE;
                  end else begin
                     state_q <= RESP;
                  end
               end
            end
            RESP: begin
               if (bus.rvalid) begin
                  rdata_q <= ld_data;
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single accesses against a
// programmable-latency bus slave, plus reset-abort sequences.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_re;
   logic        cpu_we;
   logic [2:0]  cpu_funct3;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        cpu_fault;

   lsu_bus_if #(.ADDR_W(32)) bus_if ();

   load_store_unit #(.ADDR_W(32), .BYTE_LANES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_re     (cpu_re),
      .cpu_we     (cpu_we),
      .cpu_funct3 (cpu_funct3),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .cpu_fault  (cpu_fault),
      .bus        (bus_if)
   );

   always #5 clk = ~clk;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   typedef struct {
      string       name;
      logic        re;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rword;
      int          rdly;
      int          vdly;
      int          exp_stall;
      logic        exp_fault;
      logic [31:0] exp_baddr;
      logic [3:0]  exp_strb;
      logic        exp_bwe;
      logic [31:0] exp_bwdata;
      logic [31:0] exp_rdata;
      logic        chk_w;
      logic        chk_r;
   } vec_t;

   typedef struct {
      int          stall_n;
      logic        fault_seen;
      logic        valid_seen;
      logic        valid_stable;
      logic        done_ok;
      logic        fault_after;
      logic        valid_after;
      logic [31:0] baddr;
      logic [31:0] bwdata;
      logic [3:0]  strb;
      logic        bwe;
      logic [31:0] rdata;
      logic [31:0] rdata_after;
   } res_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic vec_t mk_load(input string name, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] rword,
                                    input int rdly, input int vdly, input int stall,
                                    input logic [31:0] baddr, input logic [31:0] rdata);
      vec_t v;
      v.name = name; v.re = 1'b1; v.we = 1'b0; v.f3 = f3; v.addr = addr;
      v.wdata = 32'h5555_AAAA; v.rword = rword; v.rdly = rdly; v.vdly = vdly;
      v.exp_stall = stall; v.exp_fault = 1'b0; v.exp_baddr = baddr;
      v.exp_strb = 4'b0000; v.exp_bwe = 1'b0; v.exp_bwdata = '0;
      v.exp_rdata = rdata; v.chk_w = 1'b0; v.chk_r = 1'b1;
      return v;
   endfunction

   function automatic vec_t mk_store(input string name, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input int rdly, input int stall,
                                     input logic [31:0] baddr, input logic [3:0] strb,
                                     input logic [31:0] bwdata);
      vec_t v;
      v.name = name; v.re = 1'b0; v.we = 1'b1; v.f3 = f3; v.addr = addr;
      v.wdata = wdata; v.rword = 32'hFFFF_FFFF; v.rdly = rdly; v.vdly = 0;
      v.exp_stall = stall; v.exp_fault = 1'b0; v.exp_baddr = baddr;
      v.exp_strb = strb; v.exp_bwe = 1'b1; v.exp_bwdata = bwdata;
      v.exp_rdata = '0; v.chk_w = 1'b1; v.chk_r = 1'b0;
      return v;
   endfunction

   function automatic vec_t mk_fault(input string name, input logic re, input logic we,
                                     input logic [2:0] f3, input logic [31:0] addr);
      vec_t v;
      v.name = name; v.re = re; v.we = we; v.f3 = f3; v.addr = addr;
      v.wdata = 32'h1234_5678; v.rword = 32'h0; v.rdly = 0; v.vdly = 0;
      v.exp_stall = 0; v.exp_fault = 1'b1; v.exp_baddr = '0;
      v.exp_strb = '0; v.exp_bwe = 1'b0; v.exp_bwdata = '0;
      v.exp_rdata = '0; v.chk_w = 1'b0; v.chk_r = 1'b0;
      return v;
   endfunction

   // Slave model: ready after rdly valid cycles, rvalid vdly cycles after acceptance.
   task automatic run_access(input vec_t v, output res_t r);
      int   vcnt;
      int   since;
      logic acc;
      vcnt = 0; since = 0; acc = 1'b0;
      r.stall_n = 0; r.fault_seen = 1'b0; r.valid_seen = 1'b0; r.valid_stable = 1'b1;
      r.done_ok = 1'b0; r.fault_after = 1'b0; r.valid_after = 1'b0;
      r.baddr = '0; r.bwdata = '0; r.strb = '0; r.bwe = 1'b0; r.rdata = '0; r.rdata_after = '0;
      for (int c = 0; c < 40 && !r.done_ok; c++) begin
         @(negedge clk);
         cpu_re = v.re; cpu_we = v.we; cpu_funct3 = v.f3;
         cpu_addr = v.addr; cpu_wdata = v.wdata; bus_if.rdata = v.rword;
         bus_if.ready  = bus_if.valid && !acc && (vcnt == v.rdly);
         bus_if.rvalid = v.re && ((bus_if.ready && v.vdly == 0) || (acc && since == v.vdly));
         #1;
         if (cpu_stall) r.stall_n++;
         if (cpu_fault) r.fault_seen = 1'b1;
         if (bus_if.valid) begin
            if (!r.valid_seen) begin
               r.valid_seen = 1'b1;
               r.baddr = bus_if.addr; r.bwdata = bus_if.wdata;
               r.strb = bus_if.wstrb; r.bwe = bus_if.we;
            end else if (r.baddr !== bus_if.addr || r.bwdata !== bus_if.wdata ||
                         r.strb !== bus_if.wstrb || r.bwe !== bus_if.we) begin
               r.valid_stable = 1'b0;
            end
            if (bus_if.ready) begin acc = 1'b1; since = 1; end
            else vcnt++;
         end else if (acc) begin
            since++;
         end
         if (!cpu_stall) begin
            r.done_ok = 1'b1;
            r.rdata = cpu_rdata;
         end
      end
      @(negedge clk);
      cpu_re = 1'b0; cpu_we = 1'b0; bus_if.ready = 1'b0; bus_if.rvalid = 1'b0;
      #1;
      r.fault_after = cpu_fault;
      r.valid_after = bus_if.valid;
      r.rdata_after = cpu_rdata;
   endtask

   task automatic apply_vec(input vec_t v);
      res_t r;
      run_access(v, r);
      check({v.name, ".done"},        32'(r.done_ok),     32'd1);
      check({v.name, ".stall"},       32'(r.stall_n),     32'(v.exp_stall));
      check({v.name, ".fault"},       32'(r.fault_seen),  32'(v.exp_fault));
      check({v.name, ".valid_seen"},  32'(r.valid_seen),  32'(!v.exp_fault));
      check({v.name, ".fault_after"}, 32'(r.fault_after), 32'd0);
      check({v.name, ".valid_after"}, 32'(r.valid_after), 32'd0);
      if (!v.exp_fault) begin
         check({v.name, ".bus_addr"},     r.baddr,              v.exp_baddr);
         check({v.name, ".wstrb"},        32'(r.strb),          32'(v.exp_strb));
         check({v.name, ".bus_we"},       32'(r.bwe),           32'(v.exp_bwe));
         check({v.name, ".valid_stable"}, 32'(r.valid_stable),  32'd1);
      end
      if (v.chk_w) check({v.name, ".bus_wdata"}, r.bwdata, v.exp_bwdata);
      if (v.chk_r) begin
         check({v.name, ".rdata"},      r.rdata,       v.exp_rdata);
         check({v.name, ".rdata_held"}, r.rdata_after, v.exp_rdata);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      cpu_re = 1'b0; cpu_we = 1'b0; cpu_funct3 = '0; cpu_addr = '0; cpu_wdata = '0;
      bus_if.ready = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = '0;
      #1;
      check("rst.bus_valid", 32'(bus_if.valid), 32'd0);
      check("rst.bus_we",    32'(bus_if.we),    32'd0);
      check("rst.wstrb",     32'(bus_if.wstrb), 32'd0);
      check("rst.bus_addr",  bus_if.addr,       32'd0);
      check("rst.bus_wdata", bus_if.wdata,      32'd0);
      check("rst.cpu_rdata", cpu_rdata,         32'd0);
      check("rst.cpu_fault", 32'(cpu_fault),    32'd0);
      check("rst.cpu_stall", 32'(cpu_stall),    32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      vecs.push_back(mk_load("lw_104",      3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 2, 32'h104, 32'hDEADBEEF));
      vecs.push_back(mk_load("lb_103",      3'b000, 32'h103, 32'h80FF1234, 0, 0, 2, 32'h100, 32'hFFFFFF80));
      vecs.push_back(mk_load("lbu_103",     3'b100, 32'h103, 32'h80FF1234, 0, 0, 2, 32'h100, 32'h00000080));
      vecs.push_back(mk_load("lh_102",      3'b001, 32'h102, 32'h80010000, 0, 0, 2, 32'h100, 32'hFFFF8001));
      vecs.push_back(mk_load("lh_102_slow", 3'b001, 32'h102, 32'h80010000, 3, 2, 7, 32'h100, 32'hFFFF8001));
      vecs.push_back(mk_load("lhu_102",     3'b101, 32'h102, 32'h80010000, 0, 0, 2, 32'h100, 32'h00008001));
      vecs.push_back(mk_load("lb_102_dly",  3'b000, 32'h102, 32'h80FF1234, 1, 1, 4, 32'h100, 32'hFFFFFFFF));
      vecs.push_back(mk_load("lbu_101",     3'b100, 32'h101, 32'h80FF1234, 0, 0, 2, 32'h100, 32'h00000012));
      vecs.push_back(mk_load("lw_rv1",      3'b010, 32'h10C, 32'h0BADF00D, 0, 1, 3, 32'h10C, 32'h0BADF00D));
      vecs.push_back(mk_store("sb_201",     3'b000, 32'h201, 32'h000000AB, 0, 2, 32'h200, 4'b0010, 32'hABABABAB));
      vecs.push_back(mk_store("sh_202",     3'b001, 32'h202, 32'h0000BEEF, 0, 2, 32'h200, 4'b1100, 32'hBEEFBEEF));
      vecs.push_back(mk_store("sh_200",     3'b001, 32'h200, 32'h12345678, 0, 2, 32'h200, 4'b0011, 32'h56785678));
      vecs.push_back(mk_store("sw_300_dly", 3'b010, 32'h300, 32'h12345678, 2, 4, 32'h300, 4'b1111, 32'h12345678));
      vecs.push_back(mk_store("sb_203",     3'b000, 32'h203, 32'hFFFFFF5A, 0, 2, 32'h200, 4'b1000, 32'h5A5A5A5A));
      vecs.push_back(mk_fault("lw_mis_102", 1'b1, 1'b0, 3'b010, 32'h102));
      vecs.push_back(mk_fault("re_and_we",  1'b1, 1'b1, 3'b010, 32'h100));
      vecs.push_back(mk_fault("ld_f3_011",  1'b1, 1'b0, 3'b011, 32'h100));
      vecs.push_back(mk_fault("st_f3_100",  1'b0, 1'b1, 3'b100, 32'h100));
      vecs.push_back(mk_fault("sh_mis_201", 1'b0, 1'b1, 3'b001, 32'h201));
      vecs.push_back(mk_fault("lh_mis_103", 1'b1, 1'b0, 3'b001, 32'h103));

      foreach (vecs[i]) apply_vec(vecs[i]);

      // Reset while the request is waiting in ADDR: bus_valid must drop before the next edge.
      @(negedge clk);
      cpu_re = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h140;
      bus_if.ready = 1'b0; bus_if.rvalid = 1'b0;
      @(negedge clk);
      #1;
      check("rstA.valid_pre", 32'(bus_if.valid), 32'd1);
      #2;
      reset = 1'b1; cpu_re = 1'b0;
      #1;
      check("rstA.valid_async", 32'(bus_if.valid), 32'd0);
      check("rstA.stall",       32'(cpu_stall),    32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Reset while waiting in RESP, then a stray rvalid must not complete anything.
      @(negedge clk);
      cpu_re = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h180;
      @(negedge clk);
      bus_if.ready = 1'b1;
      @(negedge clk);
      bus_if.ready = 1'b0;
      #1;
      check("rstR.in_resp_stall", 32'(cpu_stall),    32'd1);
      check("rstR.in_resp_valid", 32'(bus_if.valid), 32'd0);
      #2;
      reset = 1'b1; cpu_re = 1'b0;
      #1;
      check("rstR.valid", 32'(bus_if.valid), 32'd0);
      check("rstR.stall", 32'(cpu_stall),    32'd0);
      check("rstR.rdata", cpu_rdata,         32'd0);
      @(negedge clk);
      reset = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'hCAFEF00D;
      #1;
      check("rstR.stray_stall", 32'(cpu_stall), 32'd0);
      @(negedge clk);
      bus_if.rvalid = 1'b0;
      #1;
      check("rstR.stray_rdata", cpu_rdata,       32'd0);
      check("rstR.idle_stall",  32'(cpu_stall),  32'd0);
      @(negedge clk);
      #1;
      check("rstR.rdata_held", cpu_rdata, 32'd0);

      apply_vec(mk_load("lw_after_rst", 3'b010, 32'h184, 32'h600DCAFE, 0, 0, 2, 32'h184, 32'h600DCAFE));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
